datamem_dp: RTL and testbench

//  Parametrised dual-read / single-write data memory for the DSP datapath.
//  Two registered read ports feed both MAC operands in one cycle; one write port stores results.

---
 rtl/datamem_dp.sv | 224 ++++++++++++++++++++++
 tb/tb_datamem_dp.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_dp.sv
// Dual-read / single-write data memory with circular addressing, clear sequencer and range check.
// Optional write-to-read forwarding is compiled in with DATAMEM_BYPASS_EN.
module datamem_dp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 144
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b,
    input  logic              circ_en,
    input  logic [ADDR_W-1:0] circ_base,
    input  logic [ADDR_W-1:0] circ_len,
    input  logic              circ_push,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              err_oob
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    state_e state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] head_q, head_d;
    logic clr_done_q, clr_done_d;
    logic err_oob_q, err_oob_d;
    logic rd_valid_a_q, rd_valid_a_d;
    logic rd_valid_b_q, rd_valid_b_d;
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic busy;
    logic wr_ok;
    logic wr_oob, a_oob, b_oob;
    logic [IDX_W-1:0] wr_phys, a_phys, b_phys;
    logic mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Returns {out_of_range, physical index}; the modulo uses one conditional subtract.
    function automatic logic [IDX_W:0] xlate(
        input logic [ADDR_W-1:0] addr,
        input logic              en,
        input logic [ADDR_W-1:0] head,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] len
    );
        logic [ADDR_W:0] s;
        logic [ADDR_W:0] p;
        logic            oob;
        if (en) begin
            s = {1'b0, addr} + {1'b0, head};
            if (s >= {1'b0, len}) begin
                s = s - {1'b0, len};
            end
            p   = {1'b0, base} + s;
            oob = (addr >= len) || (len == '0) || (p >= DEPTH_X);
        end else begin
            p   = {1'b0, addr};
            oob = (p >= DEPTH_X);
        end
        return {oob, p[IDX_W-1:0]};
    endfunction

    always_comb begin
        {wr_oob, wr_phys} = xlate(wr_addr, circ_en, head_q, circ_base, circ_len);
        {a_oob, a_phys}   = xlate(rd_addr_a, circ_en, head_q, circ_base, circ_len);
        {b_oob, b_phys}   = xlate(rd_addr_b, circ_en, head_q, circ_base, circ_len);
    end

    assign busy  = (state_q == ST_CLEAR);
    assign wr_ok = wr_en && !busy && !wr_oob;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        clr_busy   = busy;
        clr_done_d = busy && (ptr_q == LAST);
    end

    // The clear sequencer owns the single write port while busy
    always_comb begin
        mem_we    = busy || wr_ok;
        mem_waddr = busy ? ptr_q : wr_phys;
        mem_wdata = busy ? '0 : wr_data;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        head_d = head_q;
        if (circ_en && circ_push) begin
            if (({1'b0, head_q} + 1'b1) >= {1'b0, circ_len}) begin
                head_d = '0;
            end else begin
                head_d = head_q + 1'b1;
            end
        end
    end

    always_comb begin
        err_oob_d = !busy && ((wr_en && wr_oob) ||
                              (rd_en_a && a_oob) ||
                              (rd_en_b && b_oob));
    end

    always_comb begin
        rd_valid_a_d = rd_en_a;
        rd_data_a_d  = rd_data_a_q;
        if (rd_en_a) begin
            if (busy || a_oob) begin
                rd_data_a_d = '0;
            end else begin
                rd_data_a_d = mem[a_phys];
`ifdef DATAMEM_BYPASS_EN
                if (wr_ok && (wr_phys == a_phys)) begin
                    rd_data_a_d = wr_data;
                end
`endif
            end
        end
    end

    always_comb begin
        rd_valid_b_d = rd_en_b;
        rd_data_b_d  = rd_data_b_q;
        if (rd_en_b) begin
            if (busy || b_oob) begin
                rd_data_b_d = '0;
            end else begin
                rd_data_b_d = mem[b_phys];
`ifdef DATAMEM_BYPASS_EN
                if (wr_ok && (wr_phys == b_phys)) begin
                    rd_data_b_d = wr_data;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            clr_done_q   <= 1'b0;
            err_oob_q    <= 1'b0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
        end else begin
            head_q       <= head_d;
            clr_done_q   <= clr_done_d;
            err_oob_q    <= err_oob_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_b = rd_valid_b_q;
    assign clr_done   = clr_done_q;
    assign err_oob    = err_oob_q;

endmodule

// File: tb/tb_datamem_dp.sv
// Scoreboard bench for datamem_dp: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_datamem_dp;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 144;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en_a;
    logic [AW-1:0] rd_addr_a;
    logic [DW-1:0] rd_data_a;
    logic          rd_valid_a;
    logic          rd_en_b;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_b;
    logic          rd_valid_b;
    logic          circ_en;
    logic [AW-1:0] circ_base;
    logic [AW-1:0] circ_len;
    logic          circ_push;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic          err_oob;

    always #5 clk = ~clk;

    datamem_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_valid_a(rd_valid_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .rd_valid_b(rd_valid_b),
        .circ_en   (circ_en),
        .circ_base (circ_base),
        .circ_len  (circ_len),
        .circ_push (circ_push),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .err_oob   (err_oob)
    );

    typedef struct packed {
        logic err;
        logic busy;
        logic done;
    } cyc_t;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    cyc_t          qc[$];

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy;
    int            m_ptr;
    int            m_head;

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  mon_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Logical-to-physical map written straight from the addressing rules.
    function automatic void xl(input int addr, output int phys, output bit oob);
        int len;
        len = int'(circ_len);
        if (circ_en) begin
            if (len == 0 || addr >= len) begin
                phys = 0;
                oob  = 1;
                return;
            end
            phys = int'(circ_base) + (addr + m_head) % len;
        end else begin
            phys = addr;
        end
        oob = (phys >= DEPTH);
    endfunction

    function automatic logic [DW-1:0] rd_model(input int p, input bit oob, input int pw, input bit wok);
        if (m_busy || oob) return '0;
`ifdef DATAMEM_BYPASS_EN
        if (wok && pw == p) return wr_data;
`endif
        return m_mem[p];
    endfunction

    task automatic idle_inputs();
        wr_en     = 0;
        rd_en_a   = 0;
        rd_en_b   = 0;
        circ_push = 0;
        clr_start = 0;
    endtask

    // Apply current inputs for one clock: predict, then advance the model.
    task automatic step();
        int   pw, pa, pb;
        bit   ow, oa, ob, wok;
        cyc_t c;
        xl(int'(wr_addr), pw, ow);
        xl(int'(rd_addr_a), pa, oa);
        xl(int'(rd_addr_b), pb, ob);
        wok = wr_en && !m_busy && !ow;
        if (rd_en_a) qa.push_back(rd_model(pa, oa, pw, wok));
        if (rd_en_b) qb.push_back(rd_model(pb, ob, pw, wok));
        c.err  = !m_busy && ((wr_en && ow) || (rd_en_a && oa) || (rd_en_b && ob));
        c.done = m_busy && (m_ptr == DEPTH - 1);
        if (wok) m_mem[pw] = wr_data;
        if (m_busy) begin
            m_mem[m_ptr] = '0;
            if (m_ptr == DEPTH - 1) m_busy = 0;
            else m_ptr++;
        end else if (clr_start) begin
            m_busy = 1;
            m_ptr  = 0;
        end
        if (circ_en && circ_push && circ_len != 0)
            m_head = (m_head + 1) % int'(circ_len);
        c.busy = m_busy;
        qc.push_back(c);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("rst_busy", 32'(clr_busy), 0);
        chk("rst_done", 32'(clr_done), 0);
        chk("rst_err", 32'(err_oob), 0);
        chk("rst_valid_a", 32'(rd_valid_a), 0);
        chk("rst_valid_b", 32'(rd_valid_b), 0);
        chk("rst_data_a", 32'(rd_data_a), 0);
        chk("rst_data_b", 32'(rd_data_b), 0);
        m_busy = 0;
        m_head = 0;
        qa.delete();
        qb.delete();
        qc.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic run_clear(input bit extras);
        int busy_cnt;
        busy_cnt  = 0;
        clr_start = 1;
        step();
        clr_start = 0;
        for (int i = 0; i < DEPTH + 4 && m_busy; i++) begin
            if (extras && i == 10) begin
                wr_en     = 1;
                wr_addr   = 8'd5;
                wr_data   = 16'hBEEF;
                rd_en_a   = 1;
                rd_addr_a = 8'd5;
            end
            if (extras && i == 20) clr_start = 1;
            if (clr_busy) busy_cnt++;
            step();
            idle_inputs();
        end
        chk("clr_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i += 2) begin
            rd_en_a   = 1;
            rd_addr_a = 8'(i);
            rd_en_b   = 1;
            rd_addr_b = 8'(i + 1);
            step();
        end
        idle_inputs();
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    initial begin
        cyc_t c;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (rd_valid_a) begin
                    if (qa.size() == 0) chk("rd_a_spurious", 32'(rd_valid_a), 0);
                    else chk("rd_data_a", 32'(rd_data_a), 32'(qa.pop_front()));
                end
                if (rd_valid_b) begin
                    if (qb.size() == 0) chk("rd_b_spurious", 32'(rd_valid_b), 0);
                    else chk("rd_data_b", 32'(rd_data_b), 32'(qb.pop_front()));
                end
                if (qc.size() > 0) begin
                    c = qc.pop_front();
                    chk("err_oob", 32'(err_oob), 32'(c.err));
                    chk("clr_busy", 32'(clr_busy), 32'(c.busy));
                    chk("clr_done", 32'(clr_done), 32'(c.done));
                end else begin
                    chk("err_idle", 32'(err_oob), 0);
                    chk("done_idle", 32'(clr_done), 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        circ_en   = 0;
        circ_base = '0;
        circ_len  = '0;
        rst_n     = 1;
        m_busy    = 0;
        m_ptr     = 0;
        m_head    = 0;
        @(negedge clk);
        do_reset();
        mon_on = 1;

        // Clear with a dropped write and an ignored restart, then read back
        run_clear(1);
        read_all();

        // Basic write then read
        wr_en = 1; wr_addr = 8'd5; wr_data = 16'h1234;
        step();
        idle_inputs();
        rd_en_a = 1; rd_addr_a = 8'd5;
        step();
        idle_inputs();
        step();
        chk("hold_data_a", 32'(rd_data_a), 32'h1234);
        chk("hold_valid_a", 32'(rd_valid_a), 0);

        // Same-cycle write and read of one word
        wr_en = 1; wr_addr = 8'd7; wr_data = 16'hAAAA;
        step();
        wr_data = 16'h5555;
        rd_en_a = 1; rd_addr_a = 8'd7;
        rd_en_b = 1; rd_addr_b = 8'd7;
        step();
        idle_inputs();
        rd_en_a = 1; rd_addr_a = 8'd7;
        step();
        idle_inputs();

        // Circular region at 16, length 4
        circ_en = 1; circ_base = 8'd16; circ_len = 8'd4;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_addr = 8'(i); wr_data = 16'(10 + i);
            step();
        end
        idle_inputs();
        circ_push = 1;
        step();
        circ_push = 0;
        rd_en_a = 1; rd_addr_a = 8'd3;
        step();
        idle_inputs();
        circ_push = 1;
        repeat (3) step();
        circ_push = 0;
        rd_en_a = 1; rd_addr_a = 8'd0;
        rd_en_b = 1; rd_addr_b = 8'd3;
        step();
        idle_inputs();
        rd_en_a = 1; rd_addr_a = 8'd5;
        step();
        idle_inputs();
        step();
        circ_en = 0;

        // Out-of-range accesses, linear
        wr_en = 1; wr_addr = 8'd150; wr_data = 16'hFFFF;
        step();
        idle_inputs();
        step();
        rd_en_a = 1; rd_addr_a = 8'd150;
        rd_en_b = 1; rd_addr_b = 8'd6;
        step();
        rd_en_a = 0;
        rd_addr_b = 8'd22;
        step();
        idle_inputs();
        step();

        // Reset in the middle of a clear
        clr_start = 1;
        step();
        clr_start = 0;
        for (int i = 0; i < 50; i++) begin
            rd_en_a = 1; rd_addr_a = 8'(i);
            step();
        end
        idle_inputs();
        do_reset();
        repeat (4) step();
        run_clear(0);
        read_all();

        // Randomized traffic
        circ_base = 8'($urandom_range(100, 140));
        circ_len  = 8'($urandom_range(1, 40));
        for (int n = 0; n < 3000; n++) begin
            int hi;
            circ_en   = ($urandom % 2) == 0;
            hi        = circ_en ? int'(circ_len) + 2 : 159;
            wr_en     = ($urandom % 2) == 0;
            wr_addr   = 8'($urandom_range(0, hi));
            wr_data   = 16'($urandom);
            rd_en_a   = ($urandom % 3) != 0;
            rd_addr_a = ($urandom % 4 == 0) ? wr_addr : 8'($urandom_range(0, hi));
            rd_en_b   = ($urandom % 3) != 0;
            rd_addr_b = ($urandom % 4 == 0) ? rd_addr_a : 8'($urandom_range(0, hi));
            circ_push = ($urandom % 4) == 0;
            clr_start = ($urandom % 400) == 0;
            step();
        end
        idle_inputs();
        circ_en = 0;
        repeat (2) step();
        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        chk("qc_drained", 32'(qc.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
